// File: rtl/cclu_multi_entry.sv
// ---------------------------------------------------------------------------
// cclu_multi_entry
// Counted-lifetime lookup cache. Holds up to DEPTH {address, target, count}
// entries kept compacted in insertion order (slot 0 = oldest). Slots with an
// index below occupancy are valid. An ACCESS searches every valid entry. A
// hit returns the stored target and uses up one count. An entry whose last
// use is consumed is removed, and the younger entries move down one slot.
//
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   cmd_valid/cmd_ready   command handshake (ready low while flushing)
//   command               00 NOP, 01 ACCESS, 10 POP, 11 FLUSH
//   addres_in, target_in, counter_in   command operands
//   valid, hit, error     1-cycle response strobes (registered)
//   target_out            response target, held until the next valid
//   isFull, isEmpty, occupancy         registered post-update fill state
// ---------------------------------------------------------------------------
module cclu_multi_entry #(
  parameter int AW           = 32,
  parameter int TW           = 32,
  parameter int CW           = 32,
  parameter int DEPTH        = 16,
  parameter int REPLACE_MODE = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   command,
  input  logic [AW-1:0]                addres_in,
  input  logic [TW-1:0]                target_in,
  input  logic [CW-1:0]                counter_in,
  output logic                         valid,
  output logic                         hit,
  output logic                         error,
  output logic [TW-1:0]                target_out,
  output logic                         isFull,
  output logic                         isEmpty,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int OW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);

  localparam logic [1:0] CMD_ACCESS = 2'b01;
  localparam logic [1:0] CMD_POP    = 2'b10;
  localparam logic [1:0] CMD_FLUSH  = 2'b11;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_FLUSH = 1'b1} state_t;

  state_t          state_r, state_s;
  logic [AW-1:0]   addr_r [DEPTH];
  logic [TW-1:0]   tgt_r  [DEPTH];
  logic [CW-1:0]   cnt_r  [DEPTH];
  logic [AW-1:0]   addr_s [DEPTH];
  logic [TW-1:0]   tgt_s  [DEPTH];
  logic [CW-1:0]   cnt_s  [DEPTH];
  logic [OW-1:0]   occ_r, occ_s;
  logic            valid_s, hit_s, error_s;
  logic [TW-1:0]   tout_s;
  logic            match_found;
  logic [IW-1:0]   match_idx;

  assign occupancy = occ_r;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state: enter FLUSH only with entries to drain, leave on the last one
  always_comb begin
    state_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid && (command == CMD_FLUSH) && (occ_r != {OW{1'b0}})) begin
          state_s = ST_FLUSH;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (occ_r == OW'(1)) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_FLUSH;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM outputs: commands are accepted only in IDLE and never during reset
  always_comb begin
    cmd_ready = 1'b0;
    if ((state_r == ST_IDLE) && !reset) begin
      cmd_ready = 1'b1;
    end else begin
      cmd_ready = 1'b0;
    end
  end

  // Associative search; addresses are unique, so the first match is the only one
  always_comb begin
    match_found = 1'b0;
    match_idx   = {IW{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (!match_found && (i < int'(occ_r)) && (addr_r[i] == addres_in)) begin
        match_found = 1'b1;
        match_idx   = IW'(i);
      end else begin
        match_found = match_found;
      end
    end
  end

  // Datapath next state: entry table, occupancy and response strobes
  always_comb begin
    addr_s  = addr_r;
    tgt_s   = tgt_r;
    cnt_s   = cnt_r;
    occ_s   = occ_r;
    valid_s = 1'b0;
    hit_s   = 1'b0;
    error_s = 1'b0;
    tout_s  = target_out;
    if (state_r == ST_FLUSH) begin
      // Lowering occupancy invalidates the youngest slot
      occ_s = occ_r - OW'(1);
      if (occ_r == OW'(1)) begin
        valid_s = 1'b1;
      end else begin
        valid_s = 1'b0;
      end
    end else if (cmd_valid) begin
      case (command)
        CMD_ACCESS: begin
          if (match_found) begin
            valid_s = 1'b1;
            hit_s   = 1'b1;
            tout_s  = tgt_r[match_idx];
            if (cnt_r[match_idx] == CW'(1)) begin
              // Last use: close the gap left by the removed entry
              for (int i = 0; i < DEPTH - 1; i++) begin
                if (i >= int'(match_idx)) begin
                  addr_s[i] = addr_r[i+1];
                  tgt_s[i]  = tgt_r[i+1];
                  cnt_s[i]  = cnt_r[i+1];
                end else begin
                  addr_s[i] = addr_r[i];
                end
              end
              occ_s = occ_r - OW'(1);
            end else begin
              cnt_s[match_idx] = cnt_r[match_idx] - CW'(1);
            end
          end else if (counter_in == {CW{1'b0}}) begin
            error_s = 1'b1;
          end else if (counter_in == CW'(1)) begin
            // Single-use target: pass it through without storing
            valid_s = 1'b1;
            tout_s  = target_in;
          end else if (occ_r != OW'(DEPTH)) begin
            for (int i = 0; i < DEPTH; i++) begin
              if (i == int'(occ_r)) begin
                addr_s[i] = addres_in;
                tgt_s[i]  = target_in;
                cnt_s[i]  = counter_in - CW'(1);
              end else begin
                addr_s[i] = addr_s[i];
              end
            end
            occ_s   = occ_r + OW'(1);
            valid_s = 1'b1;
            tout_s  = target_in;
          end else if (REPLACE_MODE == 0) begin
            error_s = 1'b1;
          end else begin
            // Evict the oldest entry and append the new one at the top slot
            for (int i = 0; i < DEPTH - 1; i++) begin
              addr_s[i] = addr_r[i+1];
              tgt_s[i]  = tgt_r[i+1];
              cnt_s[i]  = cnt_r[i+1];
            end
            addr_s[DEPTH-1] = addres_in;
            tgt_s[DEPTH-1]  = target_in;
            cnt_s[DEPTH-1]  = counter_in - CW'(1);
            valid_s = 1'b1;
            tout_s  = target_in;
          end
        end
        CMD_POP: begin
          if (occ_r != {OW{1'b0}}) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
              addr_s[i] = addr_r[i+1];
              tgt_s[i]  = tgt_r[i+1];
              cnt_s[i]  = cnt_r[i+1];
            end
            occ_s   = occ_r - OW'(1);
            valid_s = 1'b1;
            tout_s  = tgt_r[0];
          end else begin
            error_s = 1'b1;
          end
        end
        CMD_FLUSH: begin
          // Non-empty flush is drained by the FLUSH state instead
          if (occ_r == {OW{1'b0}}) begin
            valid_s = 1'b1;
          end else begin
            valid_s = 1'b0;
          end
        end
        default: begin
          valid_s = 1'b0;
        end
      endcase
    end else begin
      valid_s = 1'b0;
    end
  end

  // Entry table, occupancy and registered response outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_r[i] <= {AW{1'b0}};
        tgt_r[i]  <= {TW{1'b0}};
        cnt_r[i]  <= {CW{1'b0}};
      end
      occ_r      <= {OW{1'b0}};
      valid      <= 1'b0;
      hit        <= 1'b0;
      error      <= 1'b0;
      target_out <= {TW{1'b0}};
      isFull     <= 1'b0;
      isEmpty    <= 1'b1;
    end else begin
      addr_r     <= addr_s;
      tgt_r      <= tgt_s;
      cnt_r      <= cnt_s;
      occ_r      <= occ_s;
      valid      <= valid_s;
      hit        <= hit_s;
      error      <= error_s;
      target_out <= tout_s;
      isFull     <= (occ_s == OW'(DEPTH));
      isEmpty    <= (occ_s == {OW{1'b0}});
    end
  end

endmodule

// File: tb/tb_cclu_multi_entry.sv
// Bench for cclu_multi_entry: two instances (REPLACE_MODE 0 and 1) share the
// stimulus; each is compared every cycle against a queue-based model, plus a
// directed vector table and hand-written corner-case sequences.
module tb_cclu_multi_entry;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [1:0]  command;
  logic [31:0] addres_in, target_in, counter_in;

  logic        ready_o [2];
  logic        valid_o [2];
  logic        hit_o   [2];
  logic        error_o [2];
  logic [31:0] tout_o  [2];
  logic        full_o  [2];
  logic        empty_o [2];
  logic [4:0]  occ_o   [2];

  always #5 clk = ~clk;

  cclu_multi_entry #(.DEPTH(DEPTH), .REPLACE_MODE(0)) dut0 (
    .clk(clk), .reset(rst), .cmd_valid(cmd_valid), .cmd_ready(ready_o[0]),
    .command(command), .addres_in(addres_in), .target_in(target_in),
    .counter_in(counter_in), .valid(valid_o[0]), .hit(hit_o[0]),
    .error(error_o[0]), .target_out(tout_o[0]), .isFull(full_o[0]),
    .isEmpty(empty_o[0]), .occupancy(occ_o[0]));

  cclu_multi_entry #(.DEPTH(DEPTH), .REPLACE_MODE(1)) dut1 (
    .clk(clk), .reset(rst), .cmd_valid(cmd_valid), .cmd_ready(ready_o[1]),
    .command(command), .addres_in(addres_in), .target_in(target_in),
    .counter_in(counter_in), .valid(valid_o[1]), .hit(hit_o[1]),
    .error(error_o[1]), .target_out(tout_o[1]), .isFull(full_o[1]),
    .isEmpty(empty_o[1]), .occupancy(occ_o[1]));

  // ---------------- reference model ----------------
  typedef struct {logic [31:0] a; logic [31:0] t; logic [31:0] c;} ent_t;
  ent_t        mq [2][$];
  bit          mfl  [2];
  bit          mev  [2];
  bit          meh  [2];
  bit          mee  [2];
  logic [31:0] mtout[2];
  bit          rdy_seen [2];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mq[m].delete();
      mfl[m] = 0; mev[m] = 0; meh[m] = 0; mee[m] = 0;
      mtout[m] = 32'h0;
    end
  endtask

  // One clock of the cache as described by its rules; m is also the replace mode
  task automatic model_step(input int m, input logic cv, input logic [1:0] cmd,
                            input logic [31:0] a, input logic [31:0] t, input logic [31:0] c);
    int j;
    ent_t e;
    mev[m] = 0; meh[m] = 0; mee[m] = 0;
    if (mfl[m]) begin
      void'(mq[m].pop_back());
      if (mq[m].size() == 0) begin mfl[m] = 0; mev[m] = 1; end
    end else if (cv) begin
      case (cmd)
        2'b01: begin
          j = -1;
          for (int i = 0; i < mq[m].size(); i++) if (j < 0 && mq[m][i].a == a) j = i;
          if (j >= 0) begin
            mev[m] = 1; meh[m] = 1; mtout[m] = mq[m][j].t;
            if (mq[m][j].c == 32'd1) mq[m].delete(j);
            else mq[m][j].c = mq[m][j].c - 32'd1;
          end else if (c == 32'd0) mee[m] = 1;
          else if (c == 32'd1) begin mev[m] = 1; mtout[m] = t; end
          else if (mq[m].size() < DEPTH || m == 1) begin
            if (mq[m].size() == DEPTH) void'(mq[m].pop_front());
            e.a = a; e.t = t; e.c = c - 32'd1;
            mq[m].push_back(e);
            mev[m] = 1; mtout[m] = t;
          end else mee[m] = 1;
        end
        2'b10: begin
          if (mq[m].size() > 0) begin
            mtout[m] = mq[m][0].t; void'(mq[m].pop_front()); mev[m] = 1;
          end else mee[m] = 1;
        end
        2'b11: begin
          if (mq[m].size() == 0) mev[m] = 1;
          else mfl[m] = 1;
        end
        default: ;
      endcase
    end
  endtask

  // Drive one command, advance one clock, compare both instances with the model
  task automatic step(input logic cv, input logic [1:0] cmd, input logic [31:0] a,
                      input logic [31:0] t, input logic [31:0] c);
    cmd_valid = cv; command = cmd; addres_in = a; target_in = t; counter_in = c;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("d%0d_ready", m), ready_o[m], !mfl[m]);
      rdy_seen[m] = ready_o[m];
      model_step(m, cv, cmd, a, t, c);
    end
    @(posedge clk); #1;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("d%0d_valid", m), valid_o[m], mev[m]);
      chk($sformatf("d%0d_hit", m), hit_o[m] & valid_o[m], meh[m]);
      chk($sformatf("d%0d_error", m), error_o[m], mee[m]);
      chk($sformatf("d%0d_tout", m), tout_o[m], mtout[m]);
      chk($sformatf("d%0d_occ", m), occ_o[m], mq[m].size());
      chk($sformatf("d%0d_full", m), full_o[m], mq[m].size() == DEPTH);
      chk($sformatf("d%0d_empty", m), empty_o[m], mq[m].size() == 0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0] cmd; logic [31:0] a; logic [31:0] t; logic [31:0] c;
    logic ev; logic eh; logic ee; logic [31:0] et; int eo;
  } vec_t;
  vec_t vec [15];

  initial begin
    int low;
    bit done;
    rst = 1'b1; cmd_valid = 1'b0; command = 2'b00;
    addres_in = 32'h0; target_in = 32'h0; counter_in = 32'h0;
    model_reset();

    vec[0]  = '{2'b01, 32'h10, 32'hAA, 32'd3, 1'b1, 1'b0, 1'b0, 32'hAA, 1};
    vec[1]  = '{2'b01, 32'h10, 32'h00, 32'd0, 1'b1, 1'b1, 1'b0, 32'hAA, 1};
    vec[2]  = '{2'b01, 32'h10, 32'h00, 32'd0, 1'b1, 1'b1, 1'b0, 32'hAA, 0};
    vec[3]  = '{2'b01, 32'h20, 32'h99, 32'd0, 1'b0, 1'b0, 1'b1, 32'hAA, 0};
    vec[4]  = '{2'b01, 32'h30, 32'h55, 32'd1, 1'b1, 1'b0, 1'b0, 32'h55, 0};
    vec[5]  = '{2'b01, 32'h01, 32'hA1, 32'd2, 1'b1, 1'b0, 1'b0, 32'hA1, 1};
    vec[6]  = '{2'b01, 32'h02, 32'hB2, 32'd3, 1'b1, 1'b0, 1'b0, 32'hB2, 2};
    vec[7]  = '{2'b01, 32'h03, 32'hC3, 32'd2, 1'b1, 1'b0, 1'b0, 32'hC3, 3};
    vec[8]  = '{2'b01, 32'h02, 32'h00, 32'd5, 1'b1, 1'b1, 1'b0, 32'hB2, 3};
    vec[9]  = '{2'b01, 32'h02, 32'h00, 32'd5, 1'b1, 1'b1, 1'b0, 32'hB2, 2};
    vec[10] = '{2'b10, 32'h00, 32'h00, 32'd0, 1'b1, 1'b0, 1'b0, 32'hA1, 1};
    vec[11] = '{2'b10, 32'h00, 32'h00, 32'd0, 1'b1, 1'b0, 1'b0, 32'hC3, 0};
    vec[12] = '{2'b10, 32'h00, 32'h00, 32'd0, 1'b0, 1'b0, 1'b1, 32'hC3, 0};
    vec[13] = '{2'b00, 32'h05, 32'h66, 32'd2, 1'b0, 1'b0, 1'b0, 32'hC3, 0};
    vec[14] = '{2'b11, 32'h00, 32'h00, 32'd0, 1'b1, 1'b0, 1'b0, 32'hC3, 0};

    // Reset values while reset is held
    repeat (2) @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("rst_ready", ready_o[m], 1'b0);
      chk("rst_valid", valid_o[m], 1'b0);
      chk("rst_error", error_o[m], 1'b0);
      chk("rst_tout", tout_o[m], 32'h0);
      chk("rst_occ", occ_o[m], 5'd0);
      chk("rst_empty", empty_o[m], 1'b1);
      chk("rst_full", full_o[m], 1'b0);
    end
    rst = 1'b0;

    // Table: hit/free, zero-count error, passthrough, middle removal, POP order
    for (int k = 0; k < 15; k++) begin
      step(1'b1, vec[k].cmd, vec[k].a, vec[k].t, vec[k].c);
      chk($sformatf("vec%0d_valid", k), valid_o[0], vec[k].ev);
      chk($sformatf("vec%0d_hit", k), hit_o[0] & valid_o[0], vec[k].eh);
      chk($sformatf("vec%0d_error", k), error_o[0], vec[k].ee);
      chk($sformatf("vec%0d_tout", k), tout_o[0], vec[k].et);
      chk($sformatf("vec%0d_occ", k), occ_o[0], vec[k].eo);
    end

    // Fill to capacity, then a 17th allocation under both replace modes
    for (int i = 0; i < DEPTH; i++) step(1'b1, 2'b01, 32'h100 + i, 32'h200 + i, 32'd2);
    chk("fill_full0", full_o[0], 1'b1);
    chk("fill_full1", full_o[1], 1'b1);
    step(1'b1, 2'b01, 32'h1FF, 32'h2FF, 32'd2);
    chk("over_err0", error_o[0], 1'b1);
    chk("over_occ0", occ_o[0], 5'd16);
    chk("over_valid1", valid_o[1], 1'b1);
    chk("over_occ1", occ_o[1], 5'd16);
    step(1'b1, 2'b01, 32'h100, 32'h0, 32'd0);
    chk("oldest_hit0", hit_o[0], 1'b1);
    chk("oldest_miss1", error_o[1], 1'b1);
    step(1'b1, 2'b01, 32'h1FF, 32'h0, 32'd0);
    chk("newest_hit1", hit_o[1], 1'b1);
    chk("newest_tout1", tout_o[1], 32'h2FF);
    chk("newest_miss0", error_o[0], 1'b1);

    // Flush of 5 entries with commands presented during the drain
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 2'b01, 32'h40 + i, 32'h50 + i, 32'd4);
    step(1'b1, 2'b11, 32'h0, 32'h0, 32'd0);
    low = 0; done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      step(1'b1, 2'b01, 32'h77, 32'h78, 32'd2);
      if (!rdy_seen[0]) begin
        low++;
        chk("flush_occ", occ_o[0], 5 - low);
      end else begin
        done = 1;
      end
    end
    chk("flush_ready_low", low, 5);

    // Asynchronous reset asserted between edges in the middle of a flush
    for (int i = 0; i < 3; i++) step(1'b1, 2'b01, 32'h60 + i, 32'h70 + i, 32'd3);
    step(1'b1, 2'b11, 32'h0, 32'h0, 32'd0);
    step(1'b0, 2'b00, 32'h0, 32'h0, 32'd0);
    #3 rst = 1'b1;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("arst_ready", ready_o[m], 1'b0);
      chk("arst_valid", valid_o[m], 1'b0);
      chk("arst_tout", tout_o[m], 32'h0);
      chk("arst_occ", occ_o[m], 5'd0);
      chk("arst_empty", empty_o[m], 1'b1);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      int r;
      logic [1:0] cmd;
      r = $urandom_range(0, 99);
      cmd = (r < 5) ? 2'b00 : (r < 70) ? 2'b01 : (r < 93) ? 2'b10 : 2'b11;
      step($urandom_range(0, 9) != 0, cmd, 32'($urandom_range(0, 23)),
           $urandom, 32'($urandom_range(0, 4)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
